// File: rtl/soc_system_pattern_gen_if.sv
// Avalon-ST video stream bundle (ready latency 1) between the pattern source and its sink.
interface soc_system_pattern_gen_if;
    logic        out_ready;
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_startofpacket;
    logic        out_endofpacket;

    modport master (
        input  out_ready,
        output out_valid, out_data, out_startofpacket, out_endofpacket
    );

    modport slave (
        output out_ready,
        input  out_valid, out_data, out_startofpacket, out_endofpacket
    );
endinterface

// File: rtl/soc_system_pattern_gen.sv
// Avalon-ST test-pattern source: WIDTH x HEIGHT RGB frames, ready latency 1.
// Define SOC_PATGEN_VIDEO_HEADER_EN to prefix every frame with a one-beat control header.
module soc_system_pattern_gen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [23:0]              solid_color,
    output logic                     frame_done,
    output logic                     busy,
    soc_system_pattern_gen_if.master st
);
    localparam int XW      = $clog2(WIDTH);
    localparam int YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BAR_LEN = WIDTH / 8;
    localparam int SW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(BAR_LEN - 1);

    typedef enum logic [1:0] {IDLE, HEADER, ACTIVE} state_t;

`ifdef SOC_PATGEN_VIDEO_HEADER_EN
    localparam state_t FIRST_STATE = HEADER;
    localparam logic   PIXEL_SOP   = 1'b0;
`else
    localparam state_t FIRST_STATE = ACTIVE;
    localparam logic   PIXEL_SOP   = 1'b1;
`endif

    state_t         state_reg, state_next;
    logic           ready_d_reg;
    logic [XW-1:0]  x_reg;
    logic [YW-1:0]  y_reg;
    logic [2:0]     bar_reg;
    logic [SW-1:0]  sub_reg;
    logic [1:0]     mode_reg;
    logic [23:0]    color_reg;
    logic           frame_done_reg;

    logic           valid;
    logic           pix_beat;
    logic           last_beat;
    logic           start;
    logic [7:0]     x_lo;
    logic           y_bit3;
    logic [23:0]    bar_color;
    logic [23:0]    pixel;

    assign valid     = ready_d_reg && (state_reg == ACTIVE || state_reg == HEADER);
    assign pix_beat  = valid && (state_reg == ACTIVE);
    assign last_beat = pix_beat && (x_reg == X_LAST) && (y_reg == Y_LAST);

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    start      = 1'b1;
                    state_next = FIRST_STATE;
                end
            end
            HEADER: begin
                if (valid) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                // enable is only consulted at frame boundaries, so frames never truncate
                if (last_beat) begin
                    if (enable) begin
                        start      = 1'b1;
                        state_next = FIRST_STATE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            ready_d_reg    <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
            bar_reg        <= '0;
            sub_reg        <= '0;
            mode_reg       <= '0;
            color_reg      <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ready_d_reg    <= st.out_ready;
            frame_done_reg <= last_beat;
            if (start) begin
                mode_reg  <= mode;
                color_reg <= solid_color;
                x_reg     <= '0;
                y_reg     <= '0;
                bar_reg   <= '0;
                sub_reg   <= '0;
            end else if (pix_beat) begin
                if (x_reg == X_LAST) begin
                    x_reg   <= '0;
                    bar_reg <= '0;
                    sub_reg <= '0;
                    if (y_reg != Y_LAST) begin
                        y_reg <= y_reg + 1'b1;
                    end
                end else begin
                    x_reg <= x_reg + 1'b1;
                    // bar index tracks x / (WIDTH/8) without a divider
                    if (sub_reg == SUB_LAST) begin
                        sub_reg <= '0;
                        bar_reg <= bar_reg + 1'b1;
                    end else begin
                        sub_reg <= sub_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign x_lo   = 8'(x_reg);
    assign y_bit3 = 1'(y_reg >> 3);

    always_comb begin
        case (bar_reg)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    end

    always_comb begin
        case (mode_reg)
            2'd0:    pixel = bar_color;
            2'd1:    pixel = {x_lo, x_lo, x_lo};
            2'd2:    pixel = color_reg;
            default: pixel = (x_lo[3] ^ y_bit3) ? 24'hFFFFFF : 24'h000000;
        endcase
    end

    // Header beat carries packet type 0, so its payload is all zeros
    assign st.out_valid         = valid;
    assign st.out_data          = pix_beat ? pixel : 24'h000000;
    assign st.out_startofpacket = valid && ((state_reg == HEADER) ||
                                  (PIXEL_SOP && state_reg == ACTIVE && x_reg == '0 && y_reg == '0));
    assign st.out_endofpacket   = last_beat;
    assign frame_done           = frame_done_reg;
    assign busy                 = (state_reg != IDLE);
endmodule

// File: tb/tb_soc_system_pattern_gen.sv
// Bench for soc_system_pattern_gen: two instances (8x2 and 16x16), frame-level model plus literal pins.
`timescale 1ns/1ps
module tb_soc_system_pattern_gen;
`ifdef SOC_PATGEN_VIDEO_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [2];
    logic        en   [2];
    logic [1:0]  md   [2];
    logic [23:0] col  [2];
    logic        rdy  [2];
    logic        fdone[2];
    logic        bsy  [2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat k of a frame, derived from frame geometry rather than counters
    function automatic logic [23:0] exp_pix(input int w, input int mode, input logic [23:0] c, input int k);
        int p, x, y;
        if (HDR == 1 && k == 0) return 24'h000000;
        p = k - HDR;
        x = p % w;
        y = p / w;
        case (mode)
            0: begin
                case (x / (w / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return {x[7:0], x[7:0], x[7:0]};
            2: return c;
            default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int W  = (gi == 0) ? 8 : 16;
        localparam int H  = (gi == 0) ? 2 : 16;
        localparam int NB = W * H + HDR;

        soc_system_pattern_gen_if bus ();
        assign bus.out_ready = rdy[gi];

        soc_system_pattern_gen #(.WIDTH(W), .HEIGHT(H)) dut (
            .clk        (clk),
            .reset_n    (rstn[gi]),
            .enable     (en[gi]),
            .mode       (md[gi]),
            .solid_color(col[gi]),
            .frame_done (fdone[gi]),
            .busy       (bsy[gi]),
            .st         (bus.master)
        );

        int          m_k    = 0;
        bit          m_act  = 1'b0;
        bit          m_rd   = 1'b0;
        bit          m_done = 1'b0;
        int          m_mode = 0;
        logic [23:0] m_col  = '0;
        bit          m_v;
        bit          ev;

        always @(posedge clk or negedge rstn[gi]) begin
            if (!rstn[gi]) begin
                m_k = 0; m_act = 0; m_rd = 0; m_done = 0;
            end else begin
                m_v    = m_rd && m_act;
                m_done = 0;
                if (!m_act) begin
                    if (en[gi]) begin
                        m_act = 1; m_k = 0; m_mode = int'(md[gi]); m_col = col[gi];
                    end
                end else if (m_v) begin
                    if (m_k == NB - 1) begin
                        m_done = 1;
                        if (en[gi]) begin
                            m_k = 0; m_mode = int'(md[gi]); m_col = col[gi];
                        end else begin
                            m_act = 0;
                        end
                    end else begin
                        m_k++;
                    end
                end
                m_rd = rdy[gi];
            end
        end

        always @(negedge clk) begin
            ev = m_rd && m_act;
            chk("valid", 32'(bus.out_valid), 32'(ev));
            chk("busy", 32'(bsy[gi]), 32'(m_act));
            chk("frame_done", 32'(fdone[gi]), 32'(m_done));
            if (ev) begin
                chk("data", 32'(bus.out_data), 32'(exp_pix(W, m_mode, m_col, m_k)));
                chk("sop", 32'(bus.out_startofpacket), 32'(m_k == 0));
                chk("eop", 32'(bus.out_endofpacket), 32'(m_k == NB - 1));
            end
        end
    end

    // Captured beats: {sop, eop, data}
    logic [25:0] cap0[$];
    logic [25:0] cap1[$];
    always @(negedge clk) begin
        if (g_inst[0].bus.out_valid)
            cap0.push_back({g_inst[0].bus.out_startofpacket, g_inst[0].bus.out_endofpacket, g_inst[0].bus.out_data});
        if (g_inst[1].bus.out_valid)
            cap1.push_back({g_inst[1].bus.out_startofpacket, g_inst[1].bus.out_endofpacket, g_inst[1].bus.out_data});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int i, input int limit, input string name);
        int n = 0;
        while (fdone[i] !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, limit);
        end
    endtask

    logic [23:0] bars[8];
    logic [5:0]  pat;
    logic [5:0]  obs;
    int          n, bad, eops;

    initial begin
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 0; en[i] = 0; md[i] = 0; col[i] = 0; rdy[i] = 0;
        end
        repeat (3) tick();
        chk("rst_valid", 32'(g_inst[0].bus.out_valid), 0);
        chk("rst_data", 32'(g_inst[0].bus.out_data), 0);
        chk("rst_busy", 32'(bsy[0]), 0);
        chk("rst_sop", 32'(g_inst[1].bus.out_startofpacket), 0);
        rstn[0] = 1; rstn[1] = 1;
        tick();

        // Colour bars, 8x2, continuous ready
        cap0.delete();
        md[0] = 0; rdy[0] = 1; en[0] = 1;
        tick();
        en[0] = 0;
        wait_done(0, 100, "bars_done");
        repeat (2) tick();
        chk("bars_len", 32'(cap0.size()), 32'(16 + HDR));
        if (cap0.size() == 16 + HDR) begin
            for (int j = 0; j < 16; j++) chk("bars_pix", 32'(cap0[j + HDR][23:0]), 32'(bars[j % 8]));
            chk("bars_sop", 32'(cap0[0][25]), 1);
            chk("bars_eop", 32'(cap0[15 + HDR][24]), 1);
        end

        // Ready latency: valid lags ready by one cycle, gradient stays continuous
        cap0.delete();
        md[0] = 1; rdy[0] = 0; en[0] = 1;
        tick();
        en[0] = 0;
        pat = 6'b011001;  // bit j is cycle j: 1,0,0,1,1,0
        for (int j = 0; j < 6; j++) begin
            rdy[0] = pat[j];
            obs[j] = g_inst[0].bus.out_valid;
            tick();
        end
        chk("rl_valid_seq", 32'(obs), 32'(6'b110010));  // 0,1,0,0,1,1
        n = 0;
        while (fdone[0] !== 1'b1 && n < 200) begin
            rdy[0] = ~rdy[0];
            tick();
            n++;
        end
        chk("rl_done", 32'(n < 200), 1);
        rdy[0] = 1;
        tick();
        chk("rl_len", 32'(cap0.size()), 32'(16 + HDR));
        if (cap0.size() == 16 + HDR) begin
            for (int j = 0; j < 16; j++) chk("rl_pix", 32'(cap0[j + HDR][23:0]), 32'(24'h010101 * (j % 8)));
        end

        // Mid-frame mode/colour/enable changes are ignored on instance 1 (16x16)
        cap1.delete();
        md[1] = 2; col[1] = 24'h123456; rdy[1] = 1; en[1] = 1;
        repeat (10) tick();
        md[1] = 3; col[1] = 24'h000000; en[1] = 0;
        wait_done(1, 400, "mid_done");
        repeat (3) tick();
        chk("mid_len", 32'(cap1.size()), 32'(256 + HDR));
        bad = 0;
        for (int j = HDR; j < cap1.size(); j++) if (cap1[j][23:0] != 24'h123456) bad++;
        chk("mid_solid", 32'(bad), 0);
        if (cap1.size() > 0) chk("mid_eop", 32'(cap1[cap1.size() - 1][24]), 1);
        chk("mid_busy", 32'(bsy[1]), 0);
        chk("mid_valid", 32'(g_inst[1].bus.out_valid), 0);

        // Checker and wrap on 16x16
        cap1.delete();
        md[1] = 3; en[1] = 1;
        tick();
        en[1] = 0;
        wait_done(1, 400, "chk_done");
        tick();
        chk("chk_len", 32'(cap1.size()), 32'(256 + HDR));
        if (cap1.size() == 256 + HDR) begin
            chk("chk_8_0", 32'(cap1[HDR + 8][23:0]), 32'h00FFFFFF);
            chk("chk_8_8", 32'(cap1[HDR + 136][23:0]), 32'h0);
            chk("chk_15_0", 32'(cap1[HDR + 15][23:0]), 32'h00FFFFFF);
            chk("chk_0_1", 32'(cap1[HDR + 16][23:0]), 32'h0);
            chk("chk_8_1", 32'(cap1[HDR + 24][23:0]), 32'h00FFFFFF);
            eops = 0;
            for (int j = 0; j < cap1.size(); j++) eops += int'(cap1[j][24]);
            chk("chk_eop_count", 32'(eops), 1);
            chk("chk_eop_last", 32'(cap1[255 + HDR][24]), 1);
        end

        // Reset mid-frame on instance 0
        cap0.delete();
        md[0] = 0; rdy[0] = 1; en[0] = 1;
        n = 0;
        while (cap0.size() < 5 && n < 50) begin
            tick();
            n++;
        end
        chk("rst_mid_reach", 32'(n < 50), 1);
        rstn[0] = 0;
        #1;
        chk("rst_mid_valid", 32'(g_inst[0].bus.out_valid), 0);
        chk("rst_mid_busy", 32'(bsy[0]), 0);
        chk("rst_mid_data", 32'(g_inst[0].bus.out_data), 0);
        tick();
        tick();
        cap0.delete();
        rstn[0] = 1;
        n = 0;
        while (cap0.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        chk("rst_restart", 32'(n < 50), 1);
        en[0] = 0;
        if (cap0.size() > 0) begin
            chk("rst_first_sop", 32'(cap0[0][25]), 1);
            chk("rst_first_data", 32'(cap0[0][23:0]), (HDR == 1) ? 32'h0 : 32'h00FFFFFF);
        end
        wait_done(0, 100, "rst_done");
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/soc_system_pattern_gen.md
Name: soc_system_pattern_gen

Overview:
- Avalon-ST video test-pattern source that feeds the 24-bit timing adapter stage directly downstream.
- Emits frames of WIDTH x HEIGHT RGB pixels, 24 bits per beat, framed by startofpacket/endofpacket.
- The output interface uses ready latency 1, matching the adapter input. Software selects the pattern and starts or stops it through level inputs.

Parameters:
- WIDTH, 640, active pixels per line; must be a multiple of 8 and at least 8.
- HEIGHT, 480, lines per frame; at least 1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  level; while high, frames are generated back-to-back.
- mode  input  2  pattern select: 0 colour bars, 1 gradient, 2 solid, 3 checker.
- solid_color  input  24  RGB value used by mode 2.
- out_ready  input  1  sink ready, ready latency 1.
- out_valid  output  1  beat valid.
- out_data  output  24  pixel: R in [23:16], G in [15:8], B in [7:0].
- out_startofpacket  output  1  first beat of frame.
- out_endofpacket  output  1  last beat of frame.
- frame_done  output  1  one-cycle pulse after the last beat of a frame is accepted.
- busy  output  1  high while in ACTIVE (or HEADER).

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-low (reset_n). Every flop clears on assertion.
- Reset values: out_valid 0, out_data 0, out_startofpacket 0, out_endofpacket 0, frame_done 0, busy 0, x=0, y=0, ready_d=0, state IDLE.
- Ready latency 1:
  - ready_d is out_ready registered.
  - out_valid may be high in cycle N only if ready_d is high, i.e. out_ready was high in cycle N-1.
  - Every valid beat is accepted; there is no backpressure on a valid beat.
  - out_valid = ready_d && state==ACTIVE, or HEADER when the feature is enabled.
  - Counters advance only on a cycle where out_valid is high.
- State machine:
  - IDLE -> ACTIVE when enable=1. On entry, latch mode and solid_color and clear x and y.
  - ACTIVE: x increments per beat. At x=WIDTH-1, x wraps to 0 and y increments.
  - On the beat with x=WIDTH-1 and y=HEIGHT-1, pulse frame_done the next cycle. Then go to ACTIVE if enable=1 (relatch mode/solid_color, clear counters), else IDLE.
  - enable deasserted mid-frame has no effect until the frame completes. Frames are never truncated.
  - mode or solid_color changes mid-frame are ignored until the next frame start.
- Framing:
  - out_startofpacket = 1 on the first beat of a frame only.
  - out_endofpacket = 1 on the last pixel beat only.
  - WIDTH=8, HEIGHT=1 must give sop on beat 0 and eop on beat 7.
- Pixel data is combinational from latched mode, x and y, and is valid whenever out_valid is high.
  - Mode 0, colour bars: bar = x / (WIDTH/8), implemented with a bar counter and a sub-counter, no divider. Bar colours 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Mode 1, gradient: R=G=B=x[7:0]; wraps every 256 pixels.
  - Mode 2, solid: the latched solid_color.
  - Mode 3, checker: (x[3]^y[3]) ? FFFFFF : 000000.
- Counter widths: x is $clog2(WIDTH) bits; y is $clog2(HEIGHT) bits, minimum 1. No overflow past WIDTH-1 or HEIGHT-1.
- Reset mid-frame: outputs go to reset values immediately. After release, the next frame starts fresh with sop on x=0, y=0.
- out_ready toggling every cycle must yield exactly one beat per cycle that follows a high out_ready, with no lost or duplicated pixels.

Optional Feature:
- Macro: SOC_PATGEN_VIDEO_HEADER_EN.
- Defined:
  - Each frame begins with a HEADER state emitting one control beat: out_data=24'h000000 (packet type 0 in [3:0]), out_startofpacket=1, out_endofpacket=0.
  - The first pixel beat then has sop=0.
  - The header consumes one accepted beat and occupies one valid cycle under the ready-latency-1 rule.
  - A frame is WIDTH*HEIGHT+1 beats.
- Undefined: no HEADER state. The first pixel carries sop, and a frame is WIDTH*HEIGHT beats.

Test Plan:
- Colour bars: WIDTH=8, HEIGHT=2, mode=0, enable=1, out_ready=1 constant -> 16 beats: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000, repeated twice; sop on beat 0, eop on beat 15, frame_done pulse one cycle later.
- Ready latency: out_ready pattern 1,0,0,1,1,0 -> out_valid 0,1,0,0,1,1 (one-cycle lag); pixel sequence continuous with no gaps or duplicates.
- Mid-frame changes: switch mode 2 to 3 and drop enable mid-frame, with solid_color=123456 -> remaining beats stay 123456; frame completes with eop; then busy=0 and no further valid.
- Reset mid-frame: assert reset_n=0 at beat 5 -> out_valid=0 immediately; after release with enable=1, the first beat has sop=1 and x=0 data.
- Checker and wrap: WIDTH=16, HEIGHT=16, mode 3 -> pixel (8,0)=FFFFFF, (8,8)=000000; x wraps 15->0 with y increment; eop only at (15,15).
- With SOC_PATGEN_VIDEO_HEADER_EN, WIDTH=8, HEIGHT=1 -> 9 beats: header 000000 with sop, 8 bar pixels, eop on beat 8.
